// File: rtl/core_pkg.sv
// Shared core package: pipeline control state and the per-stage
// control bundle driven by pipe_ctrl.
package core;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic            if_en;
        logic            id_en;
        logic            ex_en;
        logic            mem_en;
        logic            wb_en;
        logic            if_id_flush;
        logic            id_ex_flush;
        logic            ex_mem_bubble;
        logic            pc_load;
        logic [XLEN-1:0] pc_target;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_evt_counter.sv
// Wrapping event counter with synchronous reset.
module evt_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rst)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stage enables, flush/bubble strobes, PC redirect,
// deferred redirect across memory stalls and stall/flush counters.
module pipe_ctrl
    import core::*;
#(
    parameter int XLEN         = core::XLEN,
    parameter int CNT_W        = 32,
    parameter int MAX_LD_STALL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_stall,
    input  logic             mem_busy,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             pc_load,
    output logic [XLEN-1:0]  pc_target,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hzd_err
);

    localparam int RUN_W = $clog2(MAX_LD_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_LD_STALL);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_LD_STALL + 1);

    pipe_state_t      state_q, state_d;
    logic             rd_pend_q, rd_pend_d;
    logic [XLEN-1:0]  rd_pc_q, rd_pc_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             err_q, err_d;
    logic             stall_inc;
    logic             flush_inc;
    logic             redir;
    pipe_ctrl_t       ctrl;

    // A stall in the same cycle as a live redirect wins: its operands are stale.
    assign redir = rd_pend_q | (redirect_valid & ~ex_stall);

    always_comb begin
        ctrl      = '0;
        state_d   = state_q;
        rd_pend_d = rd_pend_q;
        rd_pc_d   = rd_pc_q;
        run_d     = run_q;
        err_d     = err_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        priority case (1'b1)
            rst: begin
                ctrl.if_id_flush   = 1'b1;
                ctrl.id_ex_flush   = 1'b1;
                ctrl.ex_mem_bubble = 1'b1;
                state_d   = RUN;
                rd_pend_d = 1'b0;
                rd_pc_d   = '0;
                run_d     = '0;
                err_d     = 1'b0;
            end
            mem_busy: begin
                state_d   = MEM_WAIT;
                stall_inc = 1'b1;
                if (redirect_valid && !ex_stall && !rd_pend_q) begin
                    rd_pend_d = 1'b1;
                    rd_pc_d   = redirect_pc;
                end
            end
            redir: begin
                ctrl.if_en       = 1'b1;
                ctrl.id_en       = 1'b1;
                ctrl.ex_en       = 1'b1;
                ctrl.mem_en      = 1'b1;
                ctrl.wb_en       = 1'b1;
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
                ctrl.pc_load     = 1'b1;
                ctrl.pc_target   = core::XLEN'(rd_pend_q ? rd_pc_q : redirect_pc);
                state_d   = RUN;
                rd_pend_d = 1'b0;
                flush_inc = 1'b1;
                run_d     = '0;
            end
            ex_stall: begin
                ctrl.mem_en        = 1'b1;
                ctrl.wb_en         = 1'b1;
                ctrl.ex_mem_bubble = 1'b1;
                state_d   = LD_STALL;
                stall_inc = 1'b1;
                run_d     = (run_q == RUN_SAT) ? run_q : run_q + RUN_W'(1);
                if (run_d > RUN_MAX)
                    err_d = 1'b1;
            end
            default: begin
                ctrl.if_en  = 1'b1;
                ctrl.id_en  = 1'b1;
                ctrl.ex_en  = 1'b1;
                ctrl.mem_en = 1'b1;
                ctrl.wb_en  = 1'b1;
                state_d = RUN;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        rd_pend_q <= rd_pend_d;
        rd_pc_q   <= rd_pc_d;
        run_q     <= run_d;
        err_q     <= err_d;
    end

    evt_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    evt_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

    assign if_en         = ctrl.if_en;
    assign id_en         = ctrl.id_en;
    assign ex_en         = ctrl.ex_en;
    assign mem_en        = ctrl.mem_en;
    assign wb_en         = ctrl.wb_en;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign pc_load       = ctrl.pc_load;
    assign pc_target     = XLEN'(ctrl.pc_target);
    assign hzd_err       = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model queues expected
// responses, a negedge monitor pops and compares them.
module tb_pipe_ctrl;

    localparam int MAX_LD = 1;

    logic        clk = 1'b0;
    logic        rst, ex_stall, mem_busy, redirect_valid;
    logic [31:0] redirect_pc;

    logic        if_en, id_en, ex_en, mem_en, wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_bubble, pc_load;
    logic [31:0] pc_target, stall_cnt, flush_cnt;
    logic        hzd_err;

    logic        if_en4, id_en4, ex_en4, mem_en4, wb_en4;
    logic        if_id_flush4, id_ex_flush4, ex_mem_bubble4, pc_load4;
    logic [31:0] pc_target4;
    logic [3:0]  stall_cnt4, flush_cnt4;
    logic        hzd_err4;

    always #5 clk = ~clk;

    pipe_ctrl #(.XLEN(32), .CNT_W(32), .MAX_LD_STALL(MAX_LD)) dut (
        .clk(clk), .rst(rst), .ex_stall(ex_stall), .mem_busy(mem_busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en),
        .wb_en(wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_bubble(ex_mem_bubble), .pc_load(pc_load),
        .pc_target(pc_target), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .hzd_err(hzd_err)
    );

    pipe_ctrl #(.XLEN(32), .CNT_W(4), .MAX_LD_STALL(MAX_LD)) dut4 (
        .clk(clk), .rst(rst), .ex_stall(ex_stall), .mem_busy(mem_busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_en(if_en4), .id_en(id_en4), .ex_en(ex_en4), .mem_en(mem_en4),
        .wb_en(wb_en4), .if_id_flush(if_id_flush4),
        .id_ex_flush(id_ex_flush4), .ex_mem_bubble(ex_mem_bubble4),
        .pc_load(pc_load4), .pc_target(pc_target4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .hzd_err(hzd_err4)
    );

    typedef struct {
        string       tag;
        bit [8:0]    ctl;
        bit [31:0]   tgt;
        bit          regs_ok;
        bit [31:0]   sc;
        bit [31:0]   fc;
        bit          err;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int fails  = 0;

    // Reference model state, expressed as the architectural rules.
    bit          m_known = 0;
    bit          m_pend  = 0;
    bit [31:0]   m_pc    = 0;
    int          m_run   = 0;
    bit          m_err   = 0;
    bit [31:0]   m_sc    = 0;
    bit [31:0]   m_fc    = 0;

    // ctl bit order: if id ex mem wb | if_id_fl id_ex_fl | bubble | pc_load
    function automatic exp_t model(input string tag, input bit r, s, b, v,
                                   input bit [31:0] pc);
        exp_t e;
        e.tag     = tag;
        e.regs_ok = m_known;
        e.sc      = m_sc;
        e.fc      = m_fc;
        e.err     = m_err;
        e.tgt     = 0;
        if (r) begin
            e.ctl   = 9'b00000_11_1_0;
            m_known = 1;
            m_pend  = 0;
            m_pc    = 0;
            m_run   = 0;
            m_err   = 0;
            m_sc    = 0;
            m_fc    = 0;
        end else if (b) begin
            e.ctl = 9'b00000_00_0_0;
            m_sc  = m_sc + 1;
            if (v && !s && !m_pend) begin
                m_pend = 1;
                m_pc   = pc;
            end
        end else if (m_pend || (v && !s)) begin
            e.ctl  = 9'b11111_11_0_1;
            e.tgt  = m_pend ? m_pc : pc;
            m_fc   = m_fc + 1;
            m_pend = 0;
            m_run  = 0;
        end else if (s) begin
            e.ctl = 9'b00011_00_1_0;
            m_sc  = m_sc + 1;
            m_run = m_run + 1;
            if (m_run > MAX_LD)
                m_err = 1;
        end else begin
            e.ctl = 9'b11111_00_0_0;
            m_run = 0;
        end
        return e;
    endfunction

    task automatic step(input string tag, input bit r, s, b, v,
                        input bit [31:0] pc);
        @(posedge clk);
        #1;
        rst            = r;
        ex_stall       = s;
        mem_busy       = b;
        redirect_valid = v;
        redirect_pc    = pc;
        sb.push_back(model(tag, r, s, b, v, pc));
    endtask

    task automatic chk(input string nm, input string tag,
                       input bit [31:0] act, input bit [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s/%s: got %h expected %h", tag, nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [8:0] ctl_a, ctl4_a;
            e = sb.pop_front();
            ctl_a  = {if_en, id_en, ex_en, mem_en, wb_en,
                      if_id_flush, id_ex_flush, ex_mem_bubble, pc_load};
            ctl4_a = {if_en4, id_en4, ex_en4, mem_en4, wb_en4,
                      if_id_flush4, id_ex_flush4, ex_mem_bubble4, pc_load4};
            chk("ctl", e.tag, 32'(ctl_a), 32'(e.ctl));
            chk("ctl4", e.tag, 32'(ctl4_a), 32'(e.ctl));
            chk("pc_target", e.tag, pc_target, e.tgt);
            chk("pc_target4", e.tag, pc_target4, e.tgt);
            if (e.regs_ok) begin
                chk("stall_cnt", e.tag, stall_cnt, e.sc);
                chk("flush_cnt", e.tag, flush_cnt, e.fc);
                chk("hzd_err", e.tag, 32'(hzd_err), 32'(e.err));
                chk("stall_cnt4", e.tag, 32'(stall_cnt4), e.sc & 32'hF);
                chk("flush_cnt4", e.tag, 32'(flush_cnt4), e.fc & 32'hF);
                chk("hzd_err4", e.tag, 32'(hzd_err4), 32'(e.err));
            end
        end
    end

    initial begin
        rst            = 1'b1;
        ex_stall       = 1'b0;
        mem_busy       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        for (int i = 0; i < 2; i++)
            step("reset", 1, 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom);
        step("post_reset", 0, 0, 0, 0, 0);
        step("post_reset", 0, 0, 0, 0, 0);

        step("load_use", 0, 1, 0, 0, 0);
        step("after_load_use", 0, 0, 0, 0, 0);
        step("after_load_use", 0, 0, 0, 0, 0);

        step("stuck", 0, 1, 0, 0, 0);
        step("stuck", 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step("stuck_idle", 0, 0, 0, 0, 0);
        step("reset", 1, 0, 0, 0, 0);

        step("defer_busy", 0, 0, 1, 1, 32'h100);
        step("defer_busy", 0, 0, 1, 1, 32'h200);
        step("defer_busy", 0, 0, 1, 0, 0);
        step("defer_apply", 0, 0, 0, 0, 0);
        step("defer_after", 0, 0, 0, 0, 0);

        step("stall_vs_redir", 0, 1, 0, 1, 32'h40);
        step("idle", 0, 0, 0, 0, 0);

        step("busy_then_stall", 0, 1, 1, 0, 0);
        step("busy_then_stall", 0, 1, 0, 0, 0);
        step("idle", 0, 0, 0, 0, 0);

        step("reset", 1, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++)
            step("wrap", 0, 0, 1, 0, 0);
        step("wrap_idle", 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            bit r;
            r = ($urandom_range(0, 49) == 0);
            step("random", r,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom);
        end
        step("idle", 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
